// File: rtl/rf_write_arbiter.sv
// Write-port scheduler for the 128-entry register file: two per-pipe FIFOs
// feeding one write port round-robin, with pending-write lookup for the issue stage.
module rf_write_arbiter #(
    parameter int WIDTH   = 128,
    parameter int REGBITS = 7,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ev_valid,
    input  logic [REGBITS-1:0] ev_wa,
    input  logic [WIDTH-1:0]   ev_wd,
    output logic               ev_ready,
    input  logic               od_valid,
    input  logic [REGBITS-1:0] od_wa,
    input  logic [WIDTH-1:0]   od_wd,
    output logic               od_ready,
    output logic               regwrite,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd,
    input  logic [REGBITS-1:0] chk_ra1,
    input  logic [REGBITS-1:0] chk_ra2,
    output logic               pend1,
    output logic               pend2
);

    localparam int PTRW = $clog2(DEPTH);
    localparam logic [PTRW:0] CNT_FULL = (PTRW+1)'(DEPTH);

    // Index 0 is the even pipe, index 1 the odd pipe.
    logic [REGBITS-1:0] r_wa [2][DEPTH];
    logic [WIDTH-1:0]   r_wd [2][DEPTH];
    logic [PTRW-1:0]    r_rp [2];
    logic [PTRW-1:0]    r_wp [2];
    logic [PTRW:0]      r_cnt [2];
    logic               r_last_odd;

    logic               w_in_valid [2];
    logic [REGBITS-1:0] w_in_wa [2];
    logic [WIDTH-1:0]   w_in_wd [2];
    logic [1:0]         w_ready;
    logic [1:0]         w_head_v;
    logic [1:0]         w_push;
    logic [1:0]         w_pop;
    logic               w_gnt_od;
    logic               w_regwrite;
    logic               w_hit1;
    logic               w_hit2;

    assign w_in_valid[0] = ev_valid;
    assign w_in_valid[1] = od_valid;
    assign w_in_wa[0]    = ev_wa;
    assign w_in_wa[1]    = od_wa;
    assign w_in_wd[0]    = ev_wd;
    assign w_in_wd[1]    = od_wd;

    function automatic logic entry_live(input logic [PTRW-1:0] idx,
                                        input logic [PTRW-1:0] rp,
                                        input logic [PTRW:0]   cnt);
        logic [PTRW-1:0] off;
        off = idx - rp;
        return {1'b0, off} < cnt;
    endfunction

    // Ready depends on registered count only; r0 writes handshake but never enqueue.
    always_comb begin
        w_ready  = '0;
        w_head_v = '0;
        w_push   = '0;
        for (int p = 0; p < 2; p++) begin
            w_ready[p]  = !reset && (r_cnt[p] < CNT_FULL);
            w_head_v[p] = (r_cnt[p] != '0);
            w_push[p]   = w_in_valid[p] && w_ready[p] && (w_in_wa[p] != '0);
        end
    end

    // On a tie the pipe not granted last time wins.
    assign w_gnt_od   = w_head_v[1] && (!w_head_v[0] || !r_last_odd);
    assign w_regwrite = !reset && (|w_head_v);
    assign w_pop[0]   = w_regwrite && !w_gnt_od;
    assign w_pop[1]   = w_regwrite && w_gnt_od;

    always_comb begin
        wa = r_wa[0][r_rp[0]];
        wd = r_wd[0][r_rp[0]];
        if (w_gnt_od) begin
            wa = r_wa[1][r_rp[1]];
            wd = r_wd[1][r_rp[1]];
        end
    end

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_live(PTRW'(i), r_rp[p], r_cnt[p])) begin
                    if (r_wa[p][i] == chk_ra1) w_hit1 = 1'b1;
                    if (r_wa[p][i] == chk_ra2) w_hit2 = 1'b1;
                end
            end
        end
    end

    assign pend1    = w_hit1 && (chk_ra1 != '0);
    assign pend2    = w_hit2 && (chk_ra2 != '0);
    assign regwrite = w_regwrite;
    assign ev_ready = w_ready[0];
    assign od_ready = w_ready[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                r_rp[p]  <= '0;
                r_wp[p]  <= '0;
                r_cnt[p] <= '0;
            end
            r_last_odd <= 1'b1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_push[p]) r_wp[p] <= r_wp[p] + PTRW'(1);
                if (w_pop[p])  r_rp[p] <= r_rp[p] + PTRW'(1);
                if (w_push[p] && !w_pop[p])
                    r_cnt[p] <= r_cnt[p] + (PTRW+1)'(1);
                else if (!w_push[p] && w_pop[p])
                    r_cnt[p] <= r_cnt[p] - (PTRW+1)'(1);
            end
            if (w_regwrite) r_last_odd <= w_gnt_od;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by the pointers/counts.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_push[p]) begin
                r_wa[p][r_wp[p]] <= w_in_wa[p];
                r_wd[p][r_wp[p]] <= w_in_wd[p];
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based model of the write scheduler.
module tb_rf_write_arbiter;

    localparam int WIDTH   = 128;
    localparam int REGBITS = 7;
    localparam int DEPTH   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               ev_valid, od_valid;
    logic [REGBITS-1:0] ev_wa, od_wa;
    logic [WIDTH-1:0]   ev_wd, od_wd;
    logic               ev_ready, od_ready;
    logic               regwrite;
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;
    logic [REGBITS-1:0] chk_ra1, chk_ra2;
    logic               pend1, pend2;

    always #5 clk = ~clk;

    rf_write_arbiter #(.WIDTH(WIDTH), .REGBITS(REGBITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .ev_valid(ev_valid), .ev_wa(ev_wa), .ev_wd(ev_wd), .ev_ready(ev_ready),
        .od_valid(od_valid), .od_wa(od_wa), .od_wd(od_wd), .od_ready(od_ready),
        .regwrite(regwrite), .wa(wa), .wd(wd),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .pend1(pend1), .pend2(pend2)
    );

    typedef struct packed {
        logic [REGBITS-1:0] wa;
        logic [WIDTH-1:0]   wd;
    } ent_t;

    ent_t q_ev[$];
    ent_t q_od[$];
    bit   m_last_odd = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic               exp_ev_ready, exp_od_ready, exp_regwrite, exp_gnt_od;
    logic               exp_pend1, exp_pend2;
    logic [REGBITS-1:0] exp_wa;
    logic [WIDTH-1:0]   exp_wd;

    // Reference model: what the outputs should be this cycle.
    task automatic model_predict();
        bit   ev_h, od_h;
        ent_t e;
        ev_h = (q_ev.size() != 0);
        od_h = (q_od.size() != 0);
        exp_ev_ready = !reset && (q_ev.size() < DEPTH);
        exp_od_ready = !reset && (q_od.size() < DEPTH);
        exp_regwrite = !reset && (ev_h || od_h);
        exp_gnt_od   = od_h && (!ev_h || !m_last_odd);
        exp_wa = '0;
        exp_wd = '0;
        if (exp_regwrite) begin
            e = exp_gnt_od ? q_od[0] : q_ev[0];
            exp_wa = e.wa;
            exp_wd = e.wd;
        end
        exp_pend1 = 1'b0;
        exp_pend2 = 1'b0;
        foreach (q_ev[i]) begin
            if (q_ev[i].wa == chk_ra1) exp_pend1 = 1'b1;
            if (q_ev[i].wa == chk_ra2) exp_pend2 = 1'b1;
        end
        foreach (q_od[i]) begin
            if (q_od[i].wa == chk_ra1) exp_pend1 = 1'b1;
            if (q_od[i].wa == chk_ra2) exp_pend2 = 1'b1;
        end
        exp_pend1 = exp_pend1 && (chk_ra1 != '0);
        exp_pend2 = exp_pend2 && (chk_ra2 != '0);
    endtask

    // Reference model: state change at the clock edge.
    task automatic model_commit();
        ent_t e;
        if (reset) begin
            q_ev.delete();
            q_od.delete();
            m_last_odd = 1'b1;
        end else begin
            if (exp_regwrite) begin
                if (exp_gnt_od) q_od.delete(0);
                else            q_ev.delete(0);
                m_last_odd = exp_gnt_od;
            end
            if (ev_valid && exp_ev_ready && ev_wa != '0) begin
                e.wa = ev_wa; e.wd = ev_wd; q_ev.push_back(e);
            end
            if (od_valid && exp_od_ready && od_wa != '0) begin
                e.wa = od_wa; e.wd = od_wd; q_od.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_predict();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic idle();
        ev_valid = 1'b0; ev_wa = '0; ev_wd = '0;
        od_valid = 1'b0; od_wa = '0; od_wd = '0;
        chk_ra1 = '0; chk_ra2 = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ev_valid = 1'b1; ev_wa = 7'd3; ev_wd = 128'h33;
        od_valid = 1'b1; od_wa = 7'd4; od_wd = 128'h44;
        tick();
        #1;
        n_checks++; if (ev_ready !== 1'b0) $display("FAIL reset_ev_ready: got %b want 0", ev_ready); else n_pass++;
        n_checks++; if (od_ready !== 1'b0) $display("FAIL reset_od_ready: got %b want 0", od_ready); else n_pass++;
        n_checks++; if (regwrite !== 1'b0) $display("FAIL reset_regwrite: got %b want 0", regwrite); else n_pass++;
        tick();
        reset = 1'b0;
        idle();
        chk_ra1 = 7'd3; chk_ra2 = 7'd4;
        #1;
        n_checks++; if (regwrite !== 1'b0) $display("FAIL post_reset_regwrite: got %b want 0", regwrite); else n_pass++;
        n_checks++; if (pend1 !== 1'b0 || pend2 !== 1'b0) $display("FAIL post_reset_pend: got %b%b want 00", pend1, pend2); else n_pass++;
        n_checks++; if (ev_ready !== 1'b1 || od_ready !== 1'b1) $display("FAIL post_reset_ready: got %b%b want 11", ev_ready, od_ready); else n_pass++;
        tick();
    endtask

    task automatic test_uncontended();
        apply_reset();
        ev_valid = 1'b1; ev_wa = 7'd5; ev_wd = 128'hA; chk_ra1 = 7'd5;
        #1;
        n_checks++; if (ev_ready !== 1'b1) $display("FAIL unc_ready: got %b want 1", ev_ready); else n_pass++;
        n_checks++; if (pend1 !== 1'b0) $display("FAIL unc_pend_accept: got %b want 0", pend1); else n_pass++;
        tick();
        ev_valid = 1'b0;
        #1;
        n_checks++; if (regwrite !== 1'b1) $display("FAIL unc_regwrite: got %b want 1", regwrite); else n_pass++;
        n_checks++; if (wa !== 7'd5) $display("FAIL unc_wa: got %0d want 5", wa); else n_pass++;
        n_checks++; if (wd !== 128'hA) $display("FAIL unc_wd: got %h want a", wd); else n_pass++;
        n_checks++; if (pend1 !== 1'b1) $display("FAIL unc_pend_queued: got %b want 1", pend1); else n_pass++;
        tick();
        #1;
        n_checks++; if (pend1 !== 1'b0) $display("FAIL unc_pend_landed: got %b want 0", pend1); else n_pass++;
        n_checks++; if (regwrite !== 1'b0) $display("FAIL unc_regwrite_done: got %b want 0", regwrite); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int ev_i, od_i, k, want;
        bit ev_acc, od_acc, ev_lo, od_lo;
        logic [WIDTH-1:0] want_wd;
        apply_reset();
        ev_i = 0; od_i = 0; k = 0; ev_lo = 0; od_lo = 0;
        for (int cyc = 0; cyc < 40 && k < 16; cyc++) begin
            ev_valid = (ev_i < 8); ev_wa = 7'(1 + ev_i); ev_wd = 128'(32'hE000 + ev_i);
            od_valid = (od_i < 8); od_wa = 7'(9 + od_i); od_wd = 128'(32'hD000 + od_i);
            #1;
            ev_acc = ev_valid && ev_ready;
            od_acc = od_valid && od_ready;
            if (ev_valid && !ev_ready) ev_lo = 1'b1;
            if (od_valid && !od_ready) od_lo = 1'b1;
            if (regwrite === 1'b1) begin
                want    = (k % 2 == 0) ? (1 + k / 2) : (9 + k / 2);
                want_wd = (k % 2 == 0) ? 128'(32'hE000 + k / 2) : 128'(32'hD000 + k / 2);
                n_checks++; if (wa !== 7'(want)) $display("FAIL b2b_wa[%0d]: got %0d want %0d", k, wa, want); else n_pass++;
                n_checks++; if (wd !== want_wd) $display("FAIL b2b_wd[%0d]: got %h want %h", k, wd, want_wd); else n_pass++;
                k++;
            end
            tick();
            if (ev_acc) ev_i++;
            if (od_acc) od_i++;
        end
        n_checks++; if (k !== 16) $display("FAIL b2b_write_count: got %0d want 16", k); else n_pass++;
        n_checks++; if (!(ev_lo && od_lo)) $display("FAIL b2b_ready_drop: got %b%b want 11", ev_lo, od_lo); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_r0_discard();
        apply_reset();
        od_valid = 1'b1; od_wa = 7'd0; od_wd = 128'hFF; chk_ra1 = 7'd0;
        #1;
        n_checks++; if (od_ready !== 1'b1) $display("FAIL r0_ready: got %b want 1", od_ready); else n_pass++;
        tick();
        od_valid = 1'b0;
        #1;
        n_checks++; if (regwrite !== 1'b0) $display("FAIL r0_regwrite: got %b want 0", regwrite); else n_pass++;
        n_checks++; if (pend1 !== 1'b0) $display("FAIL r0_pend: got %b want 0", pend1); else n_pass++;
        tick();
        #1;
        n_checks++; if (regwrite !== 1'b0) $display("FAIL r0_regwrite_later: got %b want 0", regwrite); else n_pass++;
        tick();
    endtask

    task automatic test_full_hold();
        apply_reset();
        ev_valid = 1'b1; ev_wa = 7'd1; ev_wd = 128'h1;
        od_valid = 1'b1; od_wa = 7'd20; od_wd = 128'h20;
        tick();
        ev_wa = 7'd2; ev_wd = 128'h2; od_wa = 7'd21; od_wd = 128'h21;
        #1;
        n_checks++; if (regwrite !== 1'b1 || wa !== 7'd1) $display("FAIL full_first_tie: got rw=%b wa=%0d want rw=1 wa=1", regwrite, wa); else n_pass++;
        tick();
        ev_wa = 7'd3; ev_wd = 128'h3; od_valid = 1'b0;
        #1;
        n_checks++; if (wa !== 7'd20) $display("FAIL full_odd_grant: got %0d want 20", wa); else n_pass++;
        tick();
        ev_wa = 7'd4; ev_wd = 128'h4;
        #1;
        n_checks++; if (ev_ready !== 1'b0) $display("FAIL full_ready_on_pop: got %b want 0", ev_ready); else n_pass++;
        n_checks++; if (regwrite !== 1'b1 || wa !== 7'd2) $display("FAIL full_even_head: got rw=%b wa=%0d want rw=1 wa=2", regwrite, wa); else n_pass++;
        tick();
        #1;
        n_checks++; if (ev_ready !== 1'b1) $display("FAIL full_ready_back: got %b want 1", ev_ready); else n_pass++;
        tick();
        idle();
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ev_valid = 1'b1; ev_wa = 7'd1; ev_wd = 128'h1;
        od_valid = 1'b1; od_wa = 7'd2; od_wd = 128'h2;
        tick();
        ev_wa = 7'd3; ev_wd = 128'h3; od_wa = 7'd4; od_wd = 128'h4;
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if (regwrite !== 1'b0) $display("FAIL mid_reset_regwrite: got %b want 0", regwrite); else n_pass++;
        n_checks++; if (ev_ready !== 1'b0 || od_ready !== 1'b0) $display("FAIL mid_reset_ready: got %b%b want 00", ev_ready, od_ready); else n_pass++;
        tick();
        reset = 1'b0;
        chk_ra1 = 7'd3; chk_ra2 = 7'd2;
        ev_wa = 7'd5; ev_wd = 128'h5; od_wa = 7'd6; od_wd = 128'h6;
        #1;
        n_checks++; if (pend1 !== 1'b0 || pend2 !== 1'b0) $display("FAIL mid_reset_pend: got %b%b want 00", pend1, pend2); else n_pass++;
        n_checks++; if (regwrite !== 1'b0) $display("FAIL mid_reset_empty: got %b want 0", regwrite); else n_pass++;
        tick();
        idle();
        #1;
        n_checks++; if (wa !== 7'd5) $display("FAIL mid_reset_tie_even: got %0d want 5", wa); else n_pass++;
        tick();
        #1;
        n_checks++; if (wa !== 7'd6) $display("FAIL mid_reset_tie_odd: got %0d want 6", wa); else n_pass++;
        tick();
    endtask

    task automatic test_pend_both();
        apply_reset();
        ev_valid = 1'b1; ev_wa = 7'd7; ev_wd = 128'h71;
        od_valid = 1'b1; od_wa = 7'd7; od_wd = 128'h72;
        chk_ra1 = 7'd7; chk_ra2 = 7'd7;
        #1;
        n_checks++; if (pend1 !== 1'b0) $display("FAIL pend_accept_cycle: got %b want 0", pend1); else n_pass++;
        tick();
        ev_valid = 1'b0; od_valid = 1'b0;
        #1;
        n_checks++; if (pend1 !== 1'b1 || pend2 !== 1'b1) $display("FAIL pend_both_q: got %b%b want 11", pend1, pend2); else n_pass++;
        n_checks++; if (wd !== 128'h71) $display("FAIL pend_first_wd: got %h want 71", wd); else n_pass++;
        tick();
        #1;
        n_checks++; if (pend1 !== 1'b1 || pend2 !== 1'b1) $display("FAIL pend_second_grant: got %b%b want 11", pend1, pend2); else n_pass++;
        n_checks++; if (wd !== 128'h72) $display("FAIL pend_second_wd: got %h want 72", wd); else n_pass++;
        tick();
        #1;
        n_checks++; if (pend1 !== 1'b0 || pend2 !== 1'b0) $display("FAIL pend_cleared: got %b%b want 00", pend1, pend2); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset    = ($urandom_range(0, 49) == 0);
            ev_valid = ($urandom_range(0, 2) != 0);
            ev_wa    = 7'($urandom_range(0, 15));
            ev_wd    = {$urandom, $urandom, $urandom, $urandom};
            od_valid = ($urandom_range(0, 2) != 0);
            od_wa    = 7'($urandom_range(0, 15));
            od_wd    = {$urandom, $urandom, $urandom, $urandom};
            chk_ra1  = 7'($urandom_range(0, 15));
            chk_ra2  = 7'($urandom_range(0, 15));
            #1;
            model_predict();
            n_checks++; if (ev_ready !== exp_ev_ready) $display("FAIL rnd_ev_ready@%0d: got %b want %b", cyc, ev_ready, exp_ev_ready); else n_pass++;
            n_checks++; if (od_ready !== exp_od_ready) $display("FAIL rnd_od_ready@%0d: got %b want %b", cyc, od_ready, exp_od_ready); else n_pass++;
            n_checks++; if (regwrite !== exp_regwrite) $display("FAIL rnd_regwrite@%0d: got %b want %b", cyc, regwrite, exp_regwrite); else n_pass++;
            n_checks++; if (pend1 !== exp_pend1) $display("FAIL rnd_pend1@%0d: got %b want %b", cyc, pend1, exp_pend1); else n_pass++;
            n_checks++; if (pend2 !== exp_pend2) $display("FAIL rnd_pend2@%0d: got %b want %b", cyc, pend2, exp_pend2); else n_pass++;
            if (exp_regwrite) begin
                n_checks++; if (wa !== exp_wa) $display("FAIL rnd_wa@%0d: got %0d want %0d", cyc, wa, exp_wa); else n_pass++;
                n_checks++; if (wd !== exp_wd) $display("FAIL rnd_wd@%0d: got %h want %h", cyc, wd, exp_wd); else n_pass++;
            end
            tick();
        end
        reset = 1'b0;
        idle();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_uncontended();
        test_back_to_back();
        test_r0_discard();
        test_full_hold();
        test_reset_mid();
        test_pend_both();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
